pc_sequencer: RTL and testbench

Fetch-side sequencer that owns the 64-bit program counter and drives instruction-memory fetches. It replaces free-running PC update with an explicit fetch/decide cycle: each fetched instruction is handed to the control unit, and the PC is updated only after the control unit's PS/PC_IN decision. It sits between the control unit (PS, PC_IN, stall, halt) and instruction memory (req/ack handshake).

---
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-side sequencer: owns the program counter, issues instruction fetches and
// applies the control unit's PS/PC_IN decision once per fetched instruction.
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PS,
    input  logic [63:0] PC_IN,
    input  logic        stall,
    input  logic        halt,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic        instr_valid,
    output logic [63:0] PC_OUT,
    output logic [63:0] PC4,
    output logic        halted,
    output logic        misalign
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DECODE,
        HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] next_pc;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = 1'b0;
        misalign_d = misalign_q;

        // Adds discard the carry, so PC+4 and PC+offset wrap modulo 2^64.
        unique case (PS)
            2'b00:   next_pc = pc_q;
            2'b01:   next_pc = pc_q + 64'd4;
            2'b10:   next_pc = PC_IN;
            default: next_pc = pc_q + PC_IN;
        endcase

        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    state_d = DECODE;
                    valid_d = 1'b1;
                end
            end
            DECODE: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (next_pc[1:0] != 2'b00) begin
                        // A misaligned target is never committed to the PC.
                        misalign_d = 1'b1;
                        state_d    = HALTED;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign PC_OUT      = pc_q;
    assign PC4         = pc_q + 64'd4;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALTED);
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of PS/PC_IN decisions plus
// hand-written ack-delay, stall, halt, misalign and reset sequences.
module tb_pc_sequencer;

    localparam logic [63:0] RV = 64'h1000;

    logic        clk;
    logic        reset;
    logic [1:0]  PS;
    logic [63:0] PC_IN;
    logic        stall;
    logic        halt;
    logic        imem_ack;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        instr_valid;
    logic [63:0] PC_OUT;
    logic [63:0] PC4;
    logic        halted;
    logic        misalign;

    pc_sequencer #(.RESET_VECTOR(RV)) dut (
        .clk        (clk),
        .reset      (reset),
        .PS         (PS),
        .PC_IN      (PC_IN),
        .stall      (stall),
        .halt       (halt),
        .imem_ack   (imem_ack),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .instr_valid(instr_valid),
        .PC_OUT     (PC_OUT),
        .PC4        (PC4),
        .halted     (halted),
        .misalign   (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [1:0]  ps;
        logic [63:0] pc_in;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] exp_q[$];
    logic [63:0] model_pc;
    logic [63:0] exp_addr;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: fetch handshakes are scored at the falling edge, outputs read 1ns after the rising edge.
    task automatic step();
        @(negedge clk);
        if (imem_req && imem_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got fetch at %h expected no fetch", imem_addr);
            end else begin
                exp_addr = exp_q.pop_front();
                check("fetch_addr", imem_addr, exp_addr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_pc_out", PC_OUT, RV);
        check("rst_imem_addr", imem_addr, RV);
        check("rst_pc4", PC4, RV + 64'd4);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        imem_ack = 1'b0;
        PS       = 2'b00;
        PC_IN    = 64'h0;
        stall    = 1'b0;
        halt     = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("boot_no_req", 64'(imem_req), 64'd0);
        model_pc = RV;
        exp_q.push_back(RV);
        step();
        check("boot_to_fetch_req", 64'(imem_req), 64'd1);
        check("boot_fetch_addr", imem_addr, RV);
    endtask

    // Called in FETCH; withholds ack for 'delay' cycles, then completes the fetch into DECODE.
    task automatic do_fetch(input int delay);
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            step();
            check("wait_req_held", 64'(imem_req), 64'd1);
            check("wait_addr_stable", imem_addr, model_pc);
            check("wait_no_valid", 64'(instr_valid), 64'd0);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("decode_valid", 64'(instr_valid), 64'd1);
        check("decode_no_req", 64'(imem_req), 64'd0);
    endtask

    // Called in DECODE; applies a decision that must land and return to FETCH.
    task automatic decide(input string name, input logic [1:0] ps, input logic [63:0] pc_in,
                          input logic [63:0] exp_pc);
        PS    = ps;
        PC_IN = pc_in;
        stall = 1'b0;
        halt  = 1'b0;
        step();
        check({name, "_pc"}, PC_OUT, exp_pc);
        check({name, "_pc4"}, PC4, exp_pc + 64'd4);
        check({name, "_req"}, 64'(imem_req), 64'd1);
        check({name, "_valid_low"}, 64'(instr_valid), 64'd0);
        model_pc = exp_pc;
        exp_q.push_back(exp_pc);
    endtask

    initial begin
        vecs[0] = '{"inc_a",      2'b01, 64'h0,                   64'h1004};
        vecs[1] = '{"inc_b",      2'b01, 64'h0,                   64'h1008};
        vecs[2] = '{"hold",       2'b00, 64'h0,                   64'h1008};
        vecs[3] = '{"load_2000",  2'b10, 64'h2000,                64'h2000};
        vecs[4] = '{"load_4000",  2'b10, 64'h4000,                64'h4000};
        vecs[5] = '{"rel_neg8",   2'b11, 64'hFFFF_FFFF_FFFF_FFF8, 64'h3FF8};
        vecs[6] = '{"rel_pos10",  2'b11, 64'h10,                  64'h4008};
        vecs[7] = '{"load_top",   2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[8] = '{"inc_wrap",   2'b01, 64'h0,                   64'h0};
        vecs[9] = '{"rel_2000",   2'b11, 64'h2000,                64'h2000};

        reset    = 1'b1;
        PS       = 2'b00;
        PC_IN    = 64'h0;
        stall    = 1'b0;
        halt     = 1'b0;
        imem_ack = 1'b0;
        model_pc = RV;
        #2;
        do_reset();

        // Back-to-back decisions with ack always immediate.
        for (int i = 0; i < 10; i++) begin
            do_fetch(0);
            decide(vecs[i].name, vecs[i].ps, vecs[i].pc_in, vecs[i].exp_pc);
        end

        // Ack withheld 3 cycles, then a 2-cycle stall in DECODE.
        do_fetch(3);
        stall = 1'b1;
        PS    = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_no_repulse", 64'(instr_valid), 64'd0);
            check("stall_pc_held", PC_OUT, model_pc);
            check("stall_no_req", 64'(imem_req), 64'd0);
        end
        decide("after_stall", 2'b01, 64'h0, model_pc + 64'd4);

        // halt is ignored while stalled, taken once stall drops.
        do_fetch(0);
        stall = 1'b1;
        halt  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("halt_stalled_not_halted", 64'(halted), 64'd0);
            check("halt_stalled_pc", PC_OUT, model_pc);
        end
        stall = 1'b0;
        step();
        check("halt_taken", 64'(halted), 64'd1);
        check("halt_pc_unchanged", PC_OUT, model_pc);
        check("halt_no_req", 64'(imem_req), 64'd0);
        check("halt_no_misalign", 64'(misalign), 64'd0);
        halt     = 1'b0;
        PS       = 2'b01;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halted_stays_idle", 64'(imem_req), 64'd0);
            check("halted_pc_frozen", PC_OUT, model_pc);
        end
        imem_ack = 1'b0;

        // Misaligned absolute target from 0x2000.
        do_reset();
        do_fetch(0);
        decide("to_2000", 2'b10, 64'h2000, 64'h2000);
        do_fetch(0);
        PS    = 2'b10;
        PC_IN = 64'h4002;
        step();
        check("mis_flag", 64'(misalign), 64'd1);
        check("mis_halted", 64'(halted), 64'd1);
        check("mis_pc_kept", PC_OUT, 64'h2000);
        check("mis_no_req", 64'(imem_req), 64'd0);
        PS       = 2'b01;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            halt = (i == 1);
            step();
            check("mis_stays_idle", 64'(imem_req), 64'd0);
            check("mis_sticky", 64'(misalign), 64'd1);
        end
        imem_ack = 1'b0;
        halt     = 1'b0;

        // Reset clears misalign/halted, then a reset lands mid-FETCH with ack pending.
        do_reset();
        do_fetch(0);
        decide("pre_abort", 2'b10, 64'h2000, 64'h2000);
        imem_ack = 1'b1;
        do_reset();
        do_fetch(0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
